fetch_stage: RTL and testbench

//  IF stage and IF/ID pipeline register. Feeds decode with instrD/PCD.

---
 rtl/fetch_stage.sv | 160 ++++++++++++++++
 tb/tb_fetch_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with one outstanding memory request, plus the IF/ID register.
// Define FETCH_STATS_EN to add the fetchCnt/bubbleCnt statistics outputs.
//
// state | meaning
// REQ   | nothing outstanding; issue a request at pcF unless redirected
// WAIT  | request for pcF outstanding
// HOLD  | response for pcF buffered while decode is stalled
// DROP  | stale request outstanding after a redirect; its response is discarded
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrD,
  output logic [31:0] PCD,
  output logic        validD
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] fetchCnt,
  output logic [31:0] bubbleCnt
`endif
);

  typedef enum logic [1:0] {REQ, WAIT, HOLD, DROP} stateT;

  stateT       state, stateNext;
  logic [31:0] pcF, pcNext, pcPlus4, target;
  logic [31:0] holdInstr, holdPc;
  logic        holdLoad;
  logic        deliver;
  logic [31:0] deliverInstr, deliverPc;
  logic        loadIfId;
  logic        unusedTargetLsbs;

  assign pcPlus4          = pcF + 32'd4;
  assign target           = {PCTargetE[31:2], 2'b00};
  assign unusedTargetLsbs = ^PCTargetE[1:0];
  assign loadIfId         = ~flushD & ~stallD;

  always_comb begin
    stateNext    = state;
    pcNext       = pcF;
    imem_req     = 1'b0;
    imem_addr    = 32'h0;
    holdLoad     = 1'b0;
    deliver      = 1'b0;
    deliverInstr = NOP_INSTR;
    deliverPc    = 32'h0;
    case (state)
      REQ: begin
        if (PCSrcE) begin
          pcNext = target;
        end else begin
          imem_req  = 1'b1;
          imem_addr = pcF;
          stateNext = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (PCSrcE) begin
            pcNext    = target;
            stateNext = REQ;
          end else if (stallD) begin
            holdLoad  = 1'b1;
            stateNext = HOLD;
          end else begin
            // Deliver and issue the next fetch in the same cycle for full throughput.
            deliver      = 1'b1;
            deliverInstr = imem_rdata;
            deliverPc    = pcF;
            pcNext       = pcPlus4;
            imem_req     = 1'b1;
            imem_addr    = pcPlus4;
          end
        end else if (PCSrcE) begin
          pcNext    = target;
          stateNext = DROP;
        end
      end
      HOLD: begin
        if (PCSrcE) begin
          pcNext    = target;
          stateNext = REQ;
        end else if (!stallD) begin
          deliver      = 1'b1;
          deliverInstr = holdInstr;
          deliverPc    = holdPc;
          pcNext       = pcPlus4;
          imem_req     = 1'b1;
          imem_addr    = pcPlus4;
          stateNext    = WAIT;
        end
      end
      DROP: begin
        // A later redirect overrides an earlier one while the stale response is pending.
        if (PCSrcE) pcNext = target;
        if (imem_rvalid) stateNext = REQ;
      end
      default: stateNext = REQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= REQ;
      pcF       <= RESET_PC;
      holdInstr <= 32'h0;
      holdPc    <= 32'h0;
    end else begin
      state <= stateNext;
      pcF   <= pcNext;
      if (holdLoad) begin
        holdInstr <= imem_rdata;
        holdPc    <= pcF;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instrD <= NOP_INSTR;
      PCD    <= 32'h0;
      validD <= 1'b0;
    end else if (flushD) begin
      instrD <= NOP_INSTR;
      PCD    <= 32'h0;
      validD <= 1'b0;
    end else if (!stallD) begin
      instrD <= deliver ? deliverInstr : NOP_INSTR;
      PCD    <= deliver ? deliverPc : 32'h0;
      validD <= deliver;
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetchCnt  <= 32'h0;
      bubbleCnt <= 32'h0;
    end else if (loadIfId) begin
      if (deliver) fetchCnt <= fetchCnt + 32'd1;
      else         bubbleCnt <= bubbleCnt + 32'd1;
    end
  end
`else
  logic unusedLoadIfId;
  assign unusedLoadIfId = loadIfId;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios plus random stall/redirect/latency traffic
// checked against an in-order instruction-stream reference model and a variable-latency memory.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallD = 1'b0, flushD = 1'b0, PCSrcE = 1'b0;
  logic [31:0] PCTargetE = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instrD, PCD;
  logic        validD;
`ifdef FETCH_STATS_EN
  logic [31:0] fetchCnt, bubbleCnt;
`endif

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .stallD(stallD), .flushD(flushD), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instrD(instrD), .PCD(PCD), .validD(validD)
`ifdef FETCH_STATS_EN
    , .fetchCnt(fetchCnt), .bubbleCnt(bubbleCnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory and reference-model state
  logic        memPending;
  int          memCnt;
  logic [31:0] memAddr;
  int          latMin, latMax;
  logic [31:0] expNext;      // PC of the next instruction decode must see
  logic [31:0] expReqAddr;   // address of the next memory request
  logic        lastReq;
  logic [31:0] lastReqAddr;
  int          fetchExp, bubbleExp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[29:0], 2'b11} ^ 32'h8A5C_0000;
  endfunction

  task automatic modelReset();
    memPending = 1'b0;
    memCnt     = 0;
    memAddr    = 32'h0;
    expNext    = 32'h0;
    expReqAddr = 32'h0;
    fetchExp   = 0;
    bubbleExp  = 0;
  endtask

  // One clock cycle; called right after a falling edge, returns right after the next one.
  task automatic step(input logic st, input logic fl, input logic ps, input logic [31:0] tg);
    logic [31:0] prevInstr, prevPc;
    logic        prevValid;
    prevInstr = instrD;
    prevPc    = PCD;
    prevValid = validD;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if (memPending) begin
      memCnt = memCnt - 1;
      if (memCnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memWord(memAddr);
        memPending  = 1'b0;
      end
    end
    stallD = st; flushD = fl; PCSrcE = ps; PCTargetE = tg;
    #1;
    lastReq     = imem_req;
    lastReqAddr = imem_addr;
    if (ps) check("reqDuringRedirect", 32'(imem_req), 32'd0);
    if (imem_req) begin
      check("oneOutstanding", 32'(memPending), 32'd0);
      check("reqAddr", imem_addr, expReqAddr);
      expReqAddr = expReqAddr + 32'd4;
      memPending = 1'b1;
      memAddr    = imem_addr;
      memCnt     = int'($urandom_range(latMax, latMin));
    end else begin
      check("idleAddr", imem_addr, 32'd0);
    end
    if (ps) expReqAddr = {tg[31:2], 2'b00};
    @(posedge clk);
    @(negedge clk);
    if (fl) begin
      check("flushInstr", instrD, NOP);
      check("flushPc", PCD, 32'd0);
      check("flushValid", 32'(validD), 32'd0);
    end else if (st) begin
      check("stallInstr", instrD, prevInstr);
      check("stallPc", PCD, prevPc);
      check("stallValid", 32'(validD), 32'(prevValid));
    end else begin
      if (ps) check("redirectBubble", 32'(validD), 32'd0);
      if (validD && !ps) begin
        check("fetchPc", PCD, expNext);
        check("fetchInstr", instrD, memWord(expNext));
        expNext = expNext + 32'd4;
        fetchExp++;
      end else if (!validD) begin
        check("bubbleInstr", instrD, NOP);
        check("bubblePc", PCD, 32'd0);
        bubbleExp++;
      end
    end
    if (ps) expNext = {tg[31:2], 2'b00};
  endtask

  initial begin
    int firstValid, validCount, randFetches;
    logic [31:0] heldPc;
    logic found, saw20, gotFirstReq, gotWrap, prevWasTop;
    logic [31:0] firstReqAfter;
    logic st, ps, fl;

    modelReset();
    latMin = 1; latMax = 1;
    lastReq = 1'b0; lastReqAddr = 32'h0;
    repeat (3) @(negedge clk);
    check("rstInstr", instrD, NOP);
    check("rstPc", PCD, 32'd0);
    check("rstValid", 32'(validD), 32'd0);
    check("rstReq", 32'(imem_req), 32'd1);
    check("rstAddr", imem_addr, 32'd0);
    rst = 1'b0;

    // Streaming with single-cycle memory
    firstValid = 0; validCount = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      if (validD) begin
        validCount++;
        if (firstValid == 0) firstValid = i;
      end
    end
    check("firstFetchCycle", 32'(firstValid), 32'd2);
    check("streamCount", 32'(validCount), 32'd7);
    check("streamLastPc", PCD, 32'd24);

    // Stall while a response arrives
    heldPc = PCD;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      check("stallNoReq", 32'(lastReq), 32'd0);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("releaseValid", 32'(validD), 32'd1);
    check("releasePc", PCD, heldPc + 32'd4);
    check("releaseReq", 32'(lastReq), 32'd1);
    check("releaseReqAddr", lastReqAddr, heldPc + 32'd8);

    // Redirect while the request to 0x20 is outstanding (3-cycle latency)
    latMin = 3; latMax = 3;
    step(1'b0, 1'b0, 1'b1, 32'h0000_0020);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      if (lastReq && lastReqAddr == 32'h20) found = 1'b1;
    end
    check("req20Seen", 32'(found), 32'd1);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0100);
    saw20 = 1'b0; gotFirstReq = 1'b0; firstReqAfter = 32'hDEAD_BEEF; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      if (lastReq && !gotFirstReq) begin
        gotFirstReq = 1'b1;
        firstReqAfter = lastReqAddr;
      end
      if (validD) begin
        found = 1'b1;
        if (PCD == 32'h20) saw20 = 1'b1;
      end
    end
    check("redirectDelivered", 32'(found), 32'd1);
    check("redirectFirstReq", firstReqAfter, 32'h100);
    check("redirectPcD", PCD, 32'h100);
    check("stale20Dropped", 32'(saw20), 32'd0);

    // Flush together with stall
    latMin = 1; latMax = 1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      if (validD) found = 1'b1;
    end
    check("preFlushValid", 32'(validD), 32'd1);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0040);
    check("flushStallInstr", instrD, 32'h0000_0013);
    check("flushStallValid", 32'(validD), 32'd0);
    check("flushStallPc", PCD, 32'd0);

    // PC wrap at the top of the address space
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
    gotWrap = 1'b0; prevWasTop = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      if (lastReq) begin
        if (prevWasTop) begin
          check("wrapAddr", lastReqAddr, 32'h0);
          gotWrap = 1'b1;
        end
        prevWasTop = (lastReqAddr == 32'hFFFF_FFFC);
      end
    end
    check("wrapSeen", 32'(gotWrap), 32'd1);

    // Random traffic
    latMin = 1; latMax = 4;
    randFetches = fetchExp;
    for (int i = 0; i < 3000; i++) begin
      st = ($urandom_range(3, 0) == 0);
      ps = ($urandom_range(19, 0) == 0);
      fl = ps && ($urandom_range(1, 0) == 1);
      step(st, fl, ps, $urandom);
    end
    randFetches = fetchExp - randFetches;
    check("randomProgress", 32'(randFetches > 300), 32'd1);

`ifdef FETCH_STATS_EN
    check("fetchCnt", fetchCnt, 32'(fetchExp));
    check("bubbleCnt", bubbleCnt, 32'(bubbleExp));
`endif

    // Reset again mid-stream
    stallD = 1'b0; flushD = 1'b0; PCSrcE = 1'b0; imem_rvalid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst2Instr", instrD, NOP);
    check("rst2Pc", PCD, 32'd0);
    check("rst2Valid", 32'(validD), 32'd0);
    check("rst2Addr", imem_addr, 32'd0);
`ifdef FETCH_STATS_EN
    check("rst2FetchCnt", fetchCnt, 32'd0);
    check("rst2BubbleCnt", bubbleCnt, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
